// File: rtl/axil_cmd_master_pkg.sv
`timescale 1ns/1ps
// Shared definitions for axil_cmd_master: FSM state encoding, AXI response codes
// and the saturating error-counter step.
package axil_cmd_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Any non-OKAY code counts as an error; the counter sticks at all-ones.
    function automatic logic [15:0] err_step(input logic [15:0] cnt, input logic [1:0] resp);
        return ((resp != RESP_OKAY) && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
    endfunction

endpackage

// File: rtl/axil_cmd_master.sv
`timescale 1ns/1ps
// Purpose: turns one command (read or write) into one AXI4-Lite transaction and returns one response.
// Latency: accept -> AW/W or AR valid next cycle; B/R handshake -> rsp_valid next cycle.
// Backpressure: one transaction outstanding; cmd_ready only in IDLE; RSP holds until rsp_ready.
//
// Ports:
//   ACLK, reset            clock, asynchronous active-high reset
//   cmd_*                  command in (valid/ready, write flag, addr, wdata, wstrb)
//   rsp_*                  response out (valid/ready, write flag, rdata, resp)
//   AW*/W*/B*/AR*/R*       AXI4-Lite master channels
//   err_count              saturating count of non-OKAY responses
//   busy                   high whenever the FSM is not in IDLE
module axil_cmd_master
    import axil_cmd_master_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                reset,
    // command
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    // response
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    // AXI4-Lite write
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    // AXI4-Lite read
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY,
    // status
    output logic [15:0]         err_count,
    output logic                busy
);

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]     araddr_q, araddr_d;
    logic [15:0]           err_count_q, err_count_d;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        err_count_d = err_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_write) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                    end else begin
                        state_d   = ST_RD_REQ;
                        arvalid_d = 1'b1;
                        araddr_d  = cmd_addr;
                    end
                end
            end
            ST_WR_REQ: begin
                // A channel whose VALID is already low has completed its handshake.
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (BVALID && bready_q) begin
                    state_d     = ST_RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = BRESP;
                    err_count_d = err_step(err_count_q, BRESP);
                end
            end
            ST_RD_REQ: begin
                if (arvalid_q && ARREADY) begin
                    state_d   = ST_RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_RESP: begin
                if (RVALID && rready_q) begin
                    state_d     = ST_RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                    err_count_d = err_step(err_count_q, RRESP);
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered from the next state so both are valid in the same cycle as the state.
    assign cmd_ready_d = (state_d == ST_IDLE);
    assign busy_d      = (state_d != ST_IDLE);

    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            err_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
            err_count_q <= err_count_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign AWVALID   = awvalid_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign AWADDR    = awaddr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign ARADDR    = araddr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
`timescale 1ns/1ps
module tb_axil_cmd_master;

    localparam int TMO = 200;

    logic        ACLK = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [15:0] err_count;
    logic        busy;

    axil_cmd_master #(.ADDR_W(8), .DATA_W(32)) dut (
        .ACLK(ACLK), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .err_count(err_count), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    // Model: responses the slave side has returned but the consumer has not yet taken,
    // whether a command is in flight, and the expected saturating error count.
    typedef struct packed {
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    exp_t        exp_q[$];
    logic        inflight;
    logic [15:0] model_err;
    logic        chk_en;
    int          n_checks;
    int          n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] count_resp(input logic [15:0] c, input logic [1:0] r);
        if (r == 2'b00 || c == 16'hFFFF) return c;
        return c + 16'd1;
    endfunction

    // Compare process: checks the DUT against the model on every falling edge.
    always @(negedge ACLK) begin
        if (chk_en) begin
            check("busy", busy, inflight);
            check("cmd_ready", cmd_ready, !inflight);
            check("rsp_valid", rsp_valid, exp_q.size() != 0);
            check("err_count", err_count, model_err);
            if (exp_q.size() != 0) begin
                check("rsp_write", rsp_write, exp_q[0].w);
                check("rsp_rdata", rsp_rdata, exp_q[0].d);
                check("rsp_resp", rsp_resp, exp_q[0].r);
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic acc;
        int   n;
        n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        do begin
            acc = cmd_ready;
            @(posedge ACLK); #1;
            n++;
        end while (!acc && n < TMO);
        check("cmd_accept", acc, 1);
        cmd_valid = 1'b0;
        inflight  = 1'b1;
    endtask

    task automatic aw_chan(input int dly, input logic [7:0] ea);
        int n;
        n = 0;
        while (AWVALID !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
        check("awvalid_seen", AWVALID, 1);
        check("awaddr", AWADDR, ea);
        for (int i = 0; i < dly; i++) begin
            @(posedge ACLK); #1;
            check("awvalid_hold", AWVALID, 1);
            check("awaddr_hold", AWADDR, ea);
        end
        AWREADY = 1'b1;
        @(posedge ACLK); #1;
        AWREADY = 1'b0;
        check("awvalid_drop", AWVALID, 0);
    endtask

    task automatic w_chan(input int dly, input logic [31:0] ed, input logic [3:0] es);
        int n;
        n = 0;
        while (WVALID !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
        check("wvalid_seen", WVALID, 1);
        check("wdata", {WSTRB, WDATA}, {es, ed});
        for (int i = 0; i < dly; i++) begin
            @(posedge ACLK); #1;
            check("wvalid_hold", WVALID, 1);
            check("wdata_hold", {WSTRB, WDATA}, {es, ed});
        end
        WREADY = 1'b1;
        @(posedge ACLK); #1;
        WREADY = 1'b0;
        check("wvalid_drop", WVALID, 0);
    endtask

    task automatic b_chan(input int dly, input logic [1:0] resp, input logic abort);
        int   n;
        exp_t e;
        n = 0;
        while (BREADY !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
        check("bready_seen", BREADY, 1);
        if (!abort) begin
            for (int i = 0; i < dly; i++) begin
                @(posedge ACLK); #1;
                check("bready_hold", BREADY, 1);
            end
            BVALID = 1'b1; BRESP = resp;
            @(posedge ACLK); #1;
            BVALID = 1'b0; BRESP = 2'b00;
            check("bready_drop", BREADY, 0);
            e.w = 1'b1; e.d = 32'h0; e.r = resp;
            exp_q.push_back(e);
            model_err = count_resp(model_err, resp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd, input logic [1:0] resp);
        send_cmd(1'b1, a, d, s);
        fork
            aw_chan(awd, a);
            w_chan(wd, d, s);
        join
        b_chan(bd, resp, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] a, input int ard, input int rd,
                           input logic [31:0] data, input logic [1:0] resp);
        int   n;
        exp_t e;
        send_cmd(1'b0, a, 32'h0, 4'h0);
        n = 0;
        while (ARVALID !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
        check("arvalid_seen", ARVALID, 1);
        check("araddr", ARADDR, a);
        for (int i = 0; i < ard; i++) begin
            @(posedge ACLK); #1;
            check("arvalid_hold", ARVALID, 1);
            check("araddr_hold", ARADDR, a);
        end
        ARREADY = 1'b1;
        @(posedge ACLK); #1;
        ARREADY = 1'b0;
        check("arvalid_drop", ARVALID, 0);
        n = 0;
        while (RREADY !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
        check("rready_seen", RREADY, 1);
        for (int i = 0; i < rd; i++) begin
            @(posedge ACLK); #1;
            check("rready_hold", RREADY, 1);
        end
        RVALID = 1'b1; RDATA = data; RRESP = resp;
        @(posedge ACLK); #1;
        RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
        check("rready_drop", RREADY, 0);
        e.w = 1'b0; e.d = data; e.r = resp;
        exp_q.push_back(e);
        model_err = count_resp(model_err, resp);
    endtask

    // Consume the pending response after holding rsp_ready low for 'hold' cycles;
    // with 'poke' a stray command is offered while the response is pending.
    task automatic take_rsp(input int hold, input logic poke);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < TMO) begin @(posedge ACLK); #1; n++; end
        check("rsp_valid_seen", rsp_valid, 1);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hEE;
                cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'h3;
            end
            @(posedge ACLK); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge ACLK); #1;
        rsp_ready = 1'b0;
        void'(exp_q.pop_front());
        inflight = 1'b0;
        if (poke) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge ACLK); #1;
                check("poke_ignored", {AWVALID, WVALID, ARVALID}, 3'b000);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valids"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, busy},
              7'b0);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_err = 0; chk_en = 1'b0;
        inflight = 1'b0; model_err = 16'd0;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check_idle_outputs("reset");
        check("reset_payload", {AWADDR, WDATA, WSTRB, ARADDR, rsp_write, rsp_rdata, rsp_resp,
                                err_count}, 0);
        reset = 1'b0;
        @(posedge ACLK); #1;
        check("cmd_ready_after_release", cmd_ready, 1);
        chk_en = 1'b1;

        // Write, AWREADY and WREADY together
        do_write(8'h04, 32'hA5A5_1234, 4'hF, 0, 0, 1, 2'b00);
        check("wr1_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b00, 32'h0});
        take_rsp(0, 1'b0);

        // Write, WREADY three cycles before AWREADY
        do_write(8'h10, 32'h0BAD_F00D, 4'h5, 3, 0, 0, 2'b00);
        take_rsp(1, 1'b0);
        repeat (3) begin @(posedge ACLK); #1; end

        // Write, AWREADY first
        do_write(8'h20, 32'h1234_5678, 4'hC, 0, 2, 2, 2'b00);
        take_rsp(0, 1'b0);

        // Read with five wait cycles on R
        do_read(8'h08, 2, 5, 32'hDEAD_BEEF, 2'b00);
        check("rd1_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata},
              {1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF});
        take_rsp(0, 1'b0);

        // Response held for ten cycles with a stray command offered
        do_read(8'h0C, 0, 0, 32'hCAFE_0001, 2'b00);
        take_rsp(10, 1'b1);

        // Error counting and saturation
        do_write(8'h30, 32'h0000_0001, 4'h1, 0, 0, 0, 2'b10);
        take_rsp(0, 1'b0);
        do_write(8'h34, 32'h0000_0002, 4'h2, 1, 0, 0, 2'b10);
        check("err_after_two", err_count, 16'd2);
        take_rsp(0, 1'b0);
        force dut.err_count_q = 16'hFFFE;
        model_err = 16'hFFFE;
        @(posedge ACLK); #1;
        release dut.err_count_q;
        check("err_preload", err_count, 16'hFFFE);
        do_read(8'h40, 0, 1, 32'h5555_AAAA, 2'b10);
        check("err_to_max", err_count, 16'hFFFF);
        take_rsp(0, 1'b0);
        do_read(8'h44, 1, 0, 32'h0, 2'b11);
        check("err_saturated", err_count, 16'hFFFF);
        take_rsp(0, 1'b0);

        // Reset while waiting for B
        send_cmd(1'b1, 8'h50, 32'h7777_8888, 4'hF);
        fork
            aw_chan(0, 8'h50);
            w_chan(1, 32'h7777_8888, 4'hF);
        join
        b_chan(0, 2'b00, 1'b1);
        chk_en = 1'b0;
        reset = 1'b1;
        #1;
        check_idle_outputs("abort");
        check("abort_err_cleared", err_count, 16'd0);
        exp_q.delete();
        inflight = 1'b0;
        model_err = 16'd0;
        BVALID = 1'b1;
        repeat (2) begin @(posedge ACLK); #1; check("abort_no_rsp", rsp_valid, 0); end
        BVALID = 1'b0;
        reset = 1'b0;
        @(posedge ACLK); #1;
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_still_no_rsp", rsp_valid, 0);
        chk_en = 1'b1;

        // Recovery after reset
        do_read(8'h60, 0, 0, 32'h0123_4567, 2'b01);
        check("post_reset_err", err_count, 16'd1);
        take_rsp(0, 1'b0);
        repeat (3) begin @(posedge ACLK); #1; end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
